inst_loader: RTL
================

# inst_loader

Instruction-memory loader for the 9-bit processor: the write side of the instruction store that program-counter fetch reads. It accepts a byte stream over a valid/ready handshake and assembles each pair of bytes into one 9-bit instruction. It writes instructions to consecutive instruction-RAM addresses starting at 0 and records the base address of each program in a table. The program counter uses those base addresses when Start selects the next program.

## Interface
- IW, 9, instruction width
- AW, 10, instruction address width
- NPROG, 3, number of programs loaded before Done
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- LoadValid  in  1  LoadData is valid this cycle
- LoadReady  out  1  loader accepts a byte this cycle
- LoadData  in  8  stream byte
- WrEn  out  1  instruction-RAM write strobe, one cycle per instruction
- WrAddr  out  AW  instruction-RAM write address
- WrData  out  IW  instruction-RAM write data
- ProgSel  in  2  selects a base-table entry for reading
- ProgBase  out  AW  base address of program ProgSel (combinational read)
- ProgCount  out  2  number of completed programs
- Done  out  1  NPROG programs loaded
- Error  out  1  sticky framing or overflow error

## Operation
- Handshake: a byte transfers on a rising edge with LoadValid && LoadReady.
- LoadReady = !Reset && (state == LO || state == HI).
- States:
  - LO: waits for byte0, which holds Inst[7:0]. On transfer, latch it and go to HI.
  - HI: waits for byte1. byte1[0] = Inst[8]. byte1[7] = EOP, meaning last instruction of the program. byte1[6:1] must be 0.
  - DONE: terminal until Reset.
  - ERR: terminal until Reset.
- HI transfer with byte1[6:1] != 0: no write, go to ERR.
- HI transfer with a valid byte1:
  - Register a write with WrData = {byte1[0], latched byte0} and WrAddr = addr.
  - Increment addr.
  - Return to LO.
- EOP on a valid HI transfer:
  - ProgCount increments.
  - If the new ProgCount == NPROG, go to DONE.
  - Otherwise, table[ProgCount_new] = addr + 1. That is the address following the EOP instruction.
- table[0] is 0 after reset. Unwritten entries read 0. A ProgSel value of NPROG or more reads 0.
- Overflow:
  - A valid non-EOP write at addr = 2^AW − 1 performs the write, then goes to ERR.
  - An EOP write at 2^AW − 1 with ProgCount_new < NPROG performs the write, then goes to ERR.
- Error = (state == ERR). Done = (state == DONE).

## Timing
- Reset values:
  - LoadReady 0 while Reset is high.
  - WrEn 0, WrAddr 0, WrData 0.
  - ProgCount 0, Done 0, Error 0.
  - state LO, addr 0, all table entries 0.
- The first byte can be accepted on the first edge after Reset deasserts.
- Write latency: WrEn, WrAddr and WrData are registered. They are valid for exactly the cycle after the byte1 transfer edge.
- ProgCount, Done and Error update on the same edge as WrEn assertion for the EOP instruction.
- Back-to-back bytes are allowed with no bubbles, so sustained throughput is 1 instruction per 2 cycles.
- LoadValid low in LO or HI leaves the state unchanged. A latched byte0 is held indefinitely.
- Reset mid-instruction, for example in HI: the latched byte0 is discarded, and no write is issued on that or the following cycle. A WrEn already registered for that edge is cleared by Reset.
- The ProgBase read is combinational from the table register. It reflects a new entry in the cycle after the EOP transfer.

## Structure
- loader_pkg holds:
  - the state enum (LO, HI, DONE, ERR)
  - IW, AW and NPROG defaults
  - EOP_BIT = 7 and INST8_BIT = 0
  - localparam RSVD_MASK = 8'h7E
- The base table is a natural sub-module, prog_base_table. It has NPROG × AW registers, a write port (index, data, enable), a combinational read port on ProgSel, and table[0] hardwired to 0.
- The FSM, address counter and write register live in inst_loader.

## Test plan
- Single program:
  - Reset, then stream DC,80 (EOP).
  - Required: WrEn one cycle with WrAddr 0, WrData 9'b011011100. ProgCount 1, table[1] = 1.
- Three programs:
  - Stream DC,80 / 0B,00 / 0B,80 / 88,81.
  - Required: writes at addresses 0..3 with data 0DC, 00B, 00B, 188.
  - ProgBase for ProgSel 0, 1 and 2 reads 0, 1 and 3.
  - Done rises with the fourth WrEn. LoadReady then stays 0.
- Stalls:
  - Insert 3 idle LoadValid cycles between byte0 and byte1.
  - Required: a single correct write and no spurious WrEn.
- Framing error:
  - Send byte1 = 0x02.
  - Required: no WrEn, Error = 1, LoadReady = 0 until Reset.
- Overflow:
  - Preload addr to 1023 by streaming 1023 non-EOP instructions, then send one more non-EOP instruction.
  - Required: a write at 1023, then Error = 1.
- Reset in HI:
  - After the DC byte, assert Reset for 1 cycle.
  - Then stream 0B,80.
  - Required: only one write, at address 0 with data 00B.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

  localparam int IW    = 9;
  localparam int AW    = 10;
  localparam int NPROG = 3;

  localparam int EOP_BIT   = 7;
  localparam int INST8_BIT = 0;

  // byte1 bits that must be zero in a well-formed frame
  localparam logic [7:0] RSVD_MASK = 8'h7E;

  typedef enum logic [1:0] {
    LO   = 2'd0,
    HI   = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream in and instruction-RAM write bus out
interface inst_loader_if;
  import loader_pkg::*;

  logic          LoadValid;
  logic          LoadReady;
  logic [7:0]    LoadData;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [IW-1:0] WrData;

  // host side: sources bytes, observes instruction writes
  modport master (
    output LoadValid, LoadData,
    input  LoadReady, WrEn, WrAddr, WrData
  );

  // loader side: sinks bytes, issues instruction writes
  modport slave (
    input  LoadValid, LoadData,
    output LoadReady, WrEn, WrAddr, WrData
  );

endinterface

// File: rtl/inst_loader_prog_base_table.sv
// rtl/inst_loader_prog_base_table.sv - per-program base address table
module prog_base_table
  import loader_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [1:0]    widx,
  input  logic [AW-1:0] wdata,
  input  logic [1:0]    rsel,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] tbl [NPROG];

  // Entry 0 is never written, so program 0 always starts at address 0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NPROG; i++) tbl[i] <= '0;
    end else if (we && (widx != 2'd0) && (int'(widx) < NPROG)) begin
      tbl[widx] <= wdata;
    end
  end

  // Combinational read; out-of-range selects and entry 0 read as zero
  always_comb begin
    rdata = '0;
    if ((rsel != 2'd0) && (int'(rsel) < NPROG)) rdata = tbl[rsel];
  end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - assembles byte pairs into 9-bit instructions and loads them
module inst_loader
  import loader_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  inst_loader_if.slave   load,
  input  logic [1:0]     ProgSel,
  output logic [AW-1:0]  ProgBase,
  output logic [1:0]     ProgCount,
  output logic           Done,
  output logic           Error
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] addr;
  logic [7:0]    byte0;
  logic [1:0]    prog_count;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;

  logic          xfer;
  logic          byte1_ok;
  logic          eop;
  logic [1:0]    count_next;
  logic          tbl_we;

  assign load.LoadReady = !Reset && ((state == LO) || (state == HI));
  assign xfer           = load.LoadValid && load.LoadReady;
  assign byte1_ok       = (load.LoadData & RSVD_MASK) == 8'h00;
  assign eop            = load.LoadData[EOP_BIT];
  assign count_next     = prog_count + 2'd1;

  // Record where the next program starts, unless this EOP completes the set
  assign tbl_we = (state == HI) && xfer && byte1_ok && eop && (int'(count_next) != NPROG);

  // Loader FSM with address counter and registered RAM write port
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= LO;
      addr       <= '0;
      byte0      <= '0;
      prog_count <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        LO: begin
          if (xfer) begin
            byte0 <= load.LoadData;
            state <= HI;
          end
        end
        HI: begin
          if (xfer) begin
            if (!byte1_ok) begin
              state <= ERR;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= {load.LoadData[INST8_BIT], byte0};
              addr    <= addr + 1'b1;
              state   <= LO;
              if (eop) begin
                prog_count <= count_next;
                if (int'(count_next) == NPROG) state <= DONE;
                else if (addr == ADDR_MAX)     state <= ERR;
              end else if (addr == ADDR_MAX) begin
                state <= ERR;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  prog_base_table u_table (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (tbl_we),
    .widx  (count_next),
    .wdata (addr + 1'b1),
    .rsel  (ProgSel),
    .rdata (ProgBase)
  );

  assign load.WrEn    = wr_en;
  assign load.WrAddr  = wr_addr;
  assign load.WrData  = wr_data;
  assign ProgCount    = prog_count;
  assign Done         = (state == DONE);
  assign Error        = (state == ERR);

endmodule
